pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined signed/unsigned add/subtract unit; successor to the single-cycle 32-bit
//  carry-select adder. Operand width is split into SEG_W-bit segments, one per pipeline stage.
//  Each stage forms both carry-in candidates (0/1) for its segment and selects with the carry from
//  the previous stage. Sits between the ALU operand latch and writeback, with valid/ready on both sides.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of SEG_W
//  SEG_W   8   segment width; NSEG = WIDTH/SEG_W pipeline stages (NSEG >= 1)
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: A+B, 1: A-B
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result, mod 2^WIDTH
//  out_ovf    out  1      signed (two's-complement) overflow
//  out_cout   out  1      carry out of MSB (for SUB: 1 = no borrow)
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  - Reset (sync, high): all stage valid bits cleared; out_valid=0, out_sum=0, out_ovf=0,
//    out_cout=0, out_zero=0. in_ready=0 while reset is high. Reset mid-operation discards all
//    in-flight beats; the first beat after reset deasserts is accepted normally.
//  - Transfer rules: input beat accepted when in_valid && in_ready; output consumed when
//    out_valid && out_ready.
//  - SUB: B is replaced by ~B and the carry into segment 0 is 1. ADD: carry into segment 0 is 0.
//  - Stage k (k=0..NSEG-1) registers segment k of the sum. It computes seg0 = A_k+B_k+0 and
//    seg1 = A_k+B_k+1 and selects with the registered carry from stage k-1 (stage 0: mode carry).
//    Unprocessed upper operand segments and finished lower sum segments travel with the beat.
//  - Latency: exactly NSEG cycles from acceptance to out_valid when not stalled.
//    Throughput: 1 beat/cycle.
//  - Stall: stall = out_valid && !out_ready. While stall is high the whole pipeline holds
//    (lockstep; bubbles are not compressed) and in_ready = 0. Otherwise in_ready = 1.
//  - Outputs are registered and held stable while out_valid && !out_ready.
//    out_valid=0 data is don't-care except after reset (zeros).
//  - out_ovf = (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is the inverted B for SUB.
//    out_cout is the carry out of the final segment.
//  - NSEG==1: single-stage registered adder, latency 1.
// TESTING
//  1. WIDTH=32,SEG_W=8: ADD 0x7FFFFFFF+0x00000001 -> after 4 cycles sum=0x80000000, ovf=1,
//     cout=0, zero=0.
//  2. SUB 0x00000005-0x00000005 -> sum=0, zero=1, cout=1, ovf=0.
//     SUB 0x80000000-0x00000001 -> sum=0x7FFFFFFF, ovf=1.
//  3. Carry ripple across all segments: ADD 0x00FFFFFF+0x00000001 -> 0x01000000;
//     ADD 0xFFFFFFFF+1 -> sum=0, cout=1, ovf=0.
//  4. Back-to-back 8 beats with out_ready=1 -> 8 results in order on consecutive cycles,
//     first at cycle 4.
//  5. Hold out_ready=0 for 3 cycles with a full pipe -> in_ready=0, out_sum stable;
//     on release, no beat is lost or duplicated.
//  6. Assert reset for 1 cycle with 3 beats in flight -> out_valid=0 and outputs zero next cycle;
//     no stale beat ever emerges.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// master = producer of operands / consumer of results; slave = the arithmetic unit.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             out_cout;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cout, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cout, out_zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined carry-select add/subtract: one SEG_W-bit segment resolved per stage, lockstep stall,
// registered sum/carry/overflow/zero at the last stage.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input logic               clock,
    input logic               reset,
    pipelined_addsub_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_W;

    logic stall;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !reset && !stall;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        // Operand bits still to be processed shrink by one segment per stage; the sum grows.
        localparam int W_IN  = WIDTH - gi * SEG_W;
        localparam int W_SUM = (gi + 1) * SEG_W;

        logic             vin;
        logic             cin;
        logic [W_IN-1:0]  a_in;
        logic [W_IN-1:0]  b_in;
        logic [SEG_W:0]   seg0;
        logic [SEG_W:0]   seg1;
        logic [SEG_W:0]   seg_sel;
        logic [W_SUM-1:0] sum_d;

        logic             vld_q;
        logic             carry_q;
        logic [W_SUM-1:0] sum_q;

        if (gi == 0) begin : g_first
            assign vin   = bus.in_valid;
            assign cin   = bus.in_sub;
            assign a_in  = bus.in_a;
            assign b_in  = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign sum_d = seg_sel[SEG_W-1:0];
        end else begin : g_next
            assign vin   = g_stage[gi-1].vld_q;
            assign cin   = g_stage[gi-1].carry_q;
            assign a_in  = g_stage[gi-1].g_fwd.a_q;
            assign b_in  = g_stage[gi-1].g_fwd.b_q;
            assign sum_d = {seg_sel[SEG_W-1:0], g_stage[gi-1].sum_q};
        end

        // Both carry-in candidates are formed up front; the incoming carry only drives the mux.
        assign seg0    = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]};
        assign seg1    = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]} + (SEG_W+1)'(1);
        assign seg_sel = cin ? seg1 : seg0;

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (!stall) begin
                vld_q <= vin;
                if (vin) begin
                    carry_q <= seg_sel[SEG_W];
                    sum_q   <= sum_d;
                end
            end
        end

        if (gi < NSEG - 1) begin : g_fwd
            logic [W_IN-SEG_W-1:0] a_q;
            logic [W_IN-SEG_W-1:0] b_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall && vin) begin
                    a_q <= a_in[W_IN-1:SEG_W];
                    b_q <= b_in[W_IN-1:SEG_W];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // Here a_in/b_in hold only the top segment, so bit SEG_W-1 is the operand sign.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall && vin) begin
                    ovf_q  <= (a_in[SEG_W-1] == b_in[SEG_W-1]) &&
                              (seg_sel[SEG_W-1] != a_in[SEG_W-1]);
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign bus.out_valid = g_stage[NSEG-1].vld_q;
    assign bus.out_sum   = g_stage[NSEG-1].sum_q;
    assign bus.out_cout  = g_stage[NSEG-1].carry_q;
    assign bus.out_ovf   = g_stage[NSEG-1].g_last.ovf_q;
    assign bus.out_zero  = g_stage[NSEG-1].g_last.zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: arithmetic reference model + scoreboard checked every cycle,
// with directed vectors whose expected results are written out by hand.
module tb_pipelined_addsub;
    localparam int WIDTH = 32;
    localparam int SEG_W = 8;
    localparam int NSEG  = WIDTH / SEG_W;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
        logic        cout;
        logic        zero;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    res_t exp_q[$];
    res_t mon_r;

    logic [31:0] ta [8];
    logic [31:0] tb_v [8];
    logic        ts [8];

    // Reference: plain signed/unsigned integer arithmetic, no segments or carries.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [32:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = sub ? (sa - sb) : (sa + sb);
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
        end else begin
            u      = {1'b0, a} + {1'b0, b};
            r.sum  = u[31:0];
            r.cout = u[32];
        end
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_sub = sub;
    endtask

    // Scoreboard: sampled on the falling edge, where every handshake signal is settled.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    mon_r = '{bus.out_sum, bus.out_ovf, bus.out_cout, bus.out_zero};
                    check($sformatf("result_beat%0d", n_out), 64'(mon_r), 64'(exp_q[0]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
                n_acc++;
            end
        end
    end

    task automatic send1(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input res_t lit);
        int   lat;
        res_t got;
        check({name, "_model"}, 64'(model(a, b, sub)), 64'(lit));
        drive(a, b, sub);
        bus.in_valid = 1'b1;
        #1;
        check({name, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(NSEG));
        got = '{bus.out_sum, bus.out_ovf, bus.out_cout, bus.out_zero};
        check({name, "_out"}, 64'(got), 64'(lit));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int cyc;
        int acc_base;

        ta   = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
                 32'h7FFF_FFFF, 32'h0000_0000, 32'h00FF_00FF, 32'hDEAD_BEEF};
        tb_v = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678,
                 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_FF01, 32'h2152_4111};
        ts   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0);

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_out_sum", 64'(bus.out_sum), 64'd0);
        check("reset_flags", {61'd0, bus.out_ovf, bus.out_cout, bus.out_zero}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed vectors with hand-computed results
        send1("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, res_t'{32'h8000_0000, 1'b1, 1'b0, 1'b0});
        send1("sub_zero",    32'h0000_0005, 32'h0000_0005, 1'b1, res_t'{32'h0000_0000, 1'b0, 1'b1, 1'b1});
        send1("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, res_t'{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        send1("add_ripple",  32'h00FF_FFFF, 32'h0000_0001, 1'b0, res_t'{32'h0100_0000, 1'b0, 1'b0, 1'b0});
        send1("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, res_t'{32'h0000_0000, 1'b0, 1'b1, 1'b1});
        send1("sub_borrow",  32'h0000_0000, 32'h0000_0001, 1'b1, res_t'{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
        send1("sub_minneg",  32'h0000_0000, 32'h8000_0000, 1'b1, res_t'{32'h8000_0000, 1'b1, 1'b0, 1'b0});

        // Back-to-back beats: results on consecutive cycles starting NSEG cycles in
        bus.in_valid = 1'b1;
        drive(ta[0], tb_v[0], ts[0]);
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j < 8) drive(ta[j], tb_v[j], ts[j]);
            else       bus.in_valid = 1'b0;
            check($sformatf("b2b_out_valid_c%0d", j), {63'd0, bus.out_valid},
                  64'((j >= NSEG) && (j < NSEG + 8)));
        end
        tick();

        // Streaming with a 3-cycle output stall on a full pipe
        acc_base = n_acc;
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            bus.out_ready = !(cyc >= 5 && cyc < 8);
            bus.in_valid  = 1'b1;
            drive(ta[idx % 8] + 32'(idx), tb_v[idx % 8], ts[idx % 8]);
            #1;
            if (cyc >= 5 && cyc < 8)
                check($sformatf("stall_in_ready_c%0d", cyc), {63'd0, bus.in_ready}, 64'd0);
            if (bus.in_ready) idx++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_all_sent", 64'(idx), 64'd10);
        repeat (NSEG + 2) tick();
        check("stream_accepted", 64'(n_acc - acc_base), 64'd10);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three beats in flight
        bus.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(ta[j], tb_v[j], ts[j]);
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        reset = 1'b0;
        check("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midreset_out_sum", 64'(bus.out_sum), 64'd0);
        check("midreset_flags", {61'd0, bus.out_ovf, bus.out_cout, bus.out_zero}, 64'd0);
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("postreset_no_stale_c%0d", j), {63'd0, bus.out_valid}, 64'd0);
        end
        send1("after_reset", 32'h0000_0010, 32'h0000_0020, 1'b0, res_t'{32'h0000_0030, 1'b0, 1'b0, 1'b0});

        repeat (2) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
